// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial W-bit subtractor: captures A and B on a start edge, shifts them
// LSB-first through one full-subtractor cell with a borrow flop, and reports
// the difference, final borrow and a zero flag with a busy/done handshake.
module tt_um_serial_subtractor #(
  parameter int unsigned W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned PIN_W = 6;
  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             start_q;
  logic [W-1:0]     a_sr, a_d;
  logic [W-1:0]     b_sr, b_d;
  logic [W-1:0]     res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;

  logic start_ev;
  logic abort;
  logic diff_bit;
  logic borrow_bit;
  logic do_load;
  logic do_clear;
  logic unused_bits;

  assign start_ev   = ui_in[6] & ~start_q;
  assign abort      = ui_in[7];
  assign diff_bit   = a_sr[0] ^ b_sr[0] ^ br_q;
  assign borrow_bit = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br_q) | (b_sr[0] & br_q);

  // Operand bits above W and the spare uio inputs are intentionally ignored.
  assign unused_bits = &{1'b0, ui_in, uio_in};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    a_d      = a_sr;
    b_d      = b_sr;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    do_load  = 1'b0;
    do_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ev) do_load = 1'b1;
      end
      ST_RUN: begin
        if (abort) begin
          do_clear = 1'b1;
        end else begin
          res_d = (res_q >> 1) | (W'(diff_bit) << (W - 1));
          br_d  = borrow_bit;
          a_d   = a_sr >> 1;
          b_d   = b_sr >> 1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort)         do_clear = 1'b1;
        else if (start_ev) do_load  = 1'b1;
      end
      default: begin
        do_clear = 1'b1;
      end
    endcase

    if (do_load) begin
      a_d     = ui_in[W-1:0];
      b_d     = uio_in[W-1:0];
      res_d   = '0;
      br_d    = 1'b0;
      cnt_d   = '0;
      state_d = ST_RUN;
    end

    if (do_clear) begin
      res_d   = '0;
      br_d    = 1'b0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    zero_d = done_d & (res_d == '0);
  end

  // State and datapath registers; ena freezes everything, rst clears at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      start_q <= ui_in[6];
      a_sr    <= a_d;
      b_sr    <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign uo_out  = {zero_q, br_q, PIN_W'(res_q)};
  assign uio_out = {done_q, busy_q, 6'b00_0000};
  assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Scoreboard bench for the bit-serial subtractor: the driver pushes the
// hand-computed uo_out for each operation, the monitor pops it on done rising.
module tb_tt_um_serial_subtractor;

  localparam int unsigned W = 6;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int         checks;
  int         failures;
  logic [7:0] exp_q[$];
  logic       done_prev;
  logic [7:0] mon_exp;

  // Hand-computed vectors: A, B, expected {zero, borrow, diff[5:0]}.
  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  tt_um_serial_subtractor #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Monitor: compare the result whenever done rises.
  always @(negedge clk) begin
    if (uio_out[7] === 1'b1 && done_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got uo_out 0x%02h with no operation pending", uo_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", uo_out, mon_exp);
      end
    end
    done_prev = uio_out[7];
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present operands with a start edge; returns at the negedge after capture.
  task automatic start_op(input logic [5:0] a, input logic [5:0] b,
                          input logic [7:0] exp, input bit push, input string name);
    if (push) exp_q.push_back(exp);
    ui_in  = {2'b01, a};
    uio_in = {2'b00, b};
    @(negedge clk);
    check({name, "_busy"}, uio_out, 8'h40);
  endtask

  // Count negedges until done, bounded.
  task automatic wait_done(input int exp_n, input string name);
    int n;
    n = 0;
    while (uio_out[7] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 8'(n), 8'(exp_n));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    done_prev = 1'b0;
    rst       = 1'b1;
    ena       = 1'b1;
    ui_in     = 8'($urandom);
    uio_in    = 8'($urandom);

    vecs[0] = '{6'd45, 6'd18, 8'h1B};
    vecs[1] = '{6'd5,  6'd9,  8'h7C};
    vecs[2] = '{6'd0,  6'd63, 8'h41};
    vecs[3] = '{6'd33, 6'd33, 8'h80};
    vecs[4] = '{6'd63, 6'd0,  8'h3F};
    vecs[5] = '{6'd1,  6'd2,  8'h7F};
    vecs[6] = '{6'd32, 6'd31, 8'h01};
    vecs[7] = '{6'd0,  6'd0,  8'h80};

    // Reset with random inputs.
    tick(2);
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'hC0);
    ui_in  = 8'h00;
    uio_in = 8'h00;
    tick(1);
    rst = 1'b0;
    tick(3);
    check("idle_uio_out", uio_out, 8'h00);
    check("idle_uo_out", uo_out, 8'h00);

    // Directed table, back-to-back with start low between operations.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1, $sformatf("vec%0d", i));
      ui_in  = {2'b00, ~vecs[i].a};
      uio_in = {2'b00, ~vecs[i].b};
      wait_done(W, $sformatf("vec%0d", i));
      tick(2);
      check($sformatf("vec%0d_hold", i), uo_out, vecs[i].exp);
    end

    // Start held high across completion: exactly one operation.
    start_op(6'd12, 6'd5, 8'h07, 1'b1, "held");
    wait_done(W, "held");
    tick(6);
    check("held_single_op", uio_out, 8'h80);
    check("held_result", uo_out, 8'h07);
    ui_in = 8'h00;
    tick(1);

    // New start edge at RUN cycle 3 is ignored.
    start_op(6'd20, 6'd7, 8'h0D, 1'b1, "ign");
    ui_in = 8'h00;
    tick(2);
    ui_in  = {2'b01, 6'd0};
    uio_in = {2'b00, 6'd63};
    tick(1);
    ui_in = 8'h00;
    wait_done(W - 3, "ign");
    tick(1);

    // Abort at RUN cycle 3.
    start_op(6'd40, 6'd1, 8'h00, 1'b0, "abort");
    ui_in = 8'h00;
    tick(2);
    ui_in = 8'h80;
    tick(1);
    check("abort_uo_out", uo_out, 8'h00);
    check("abort_uio_out", uio_out, 8'h00);
    ui_in = 8'h00;
    tick(8);
    check("abort_stays_idle", uio_out, 8'h00);

    // Abort together with a start edge while in DONE.
    start_op(6'd9, 6'd3, 8'h06, 1'b1, "pre");
    ui_in = 8'h00;
    wait_done(W, "pre");
    tick(1);
    ui_in  = {2'b11, 6'd20};
    uio_in = {2'b00, 6'd4};
    tick(1);
    check("abort_start_uio_out", uio_out, 8'h00);
    check("abort_start_uo_out", uo_out, 8'h00);
    ui_in = {2'b01, 6'd20};
    tick(3);
    check("start_consumed", uio_out, 8'h00);
    ui_in = 8'h00;
    tick(1);

    // Four disabled cycles mid-RUN stretch latency one-for-one.
    start_op(6'd50, 6'd13, 8'h25, 1'b1, "stall");
    ui_in = 8'h00;
    tick(2);
    ena = 1'b0;
    tick(4);
    check("stall_busy", uio_out, 8'h40);
    ena = 1'b1;
    wait_done(W - 2, "stall");
    tick(1);

    // Async reset between edges mid-RUN.
    start_op(6'd60, 6'd3, 8'h00, 1'b0, "rstmid");
    ui_in = 8'h00;
    tick(2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_uo_out", uo_out, 8'h00);
    check("async_rst_uio_out", uio_out, 8'h00);
    check("async_rst_uio_oe", uio_oe, 8'hC0);
    #1 rst = 1'b0;
    tick(1);
    check("rst_idle", uio_out, 8'h00);
    tick(W + 2);
    check("rst_no_resume", uio_out, 8'h00);
    check("rst_no_result", uo_out, 8'h00);

    // Recovery after reset.
    start_op(6'd17, 6'd40, 8'h69, 1'b1, "recover");
    ui_in = 8'h00;
    wait_done(W, "recover");
    tick(2);

    check("scoreboard_drain", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
